// File: rtl/shift_pkg.sv
// Shared types and helpers for the sequential shift/rotate unit.
package shift_pkg;

  typedef enum logic [1:0] {
    ModeLsl = 2'b00,
    ModeLsr = 2'b01,
    ModeAsr = 2'b10,
    ModeRor = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shift_state_e;

  function automatic int unsigned amt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step.
// Rotate is present only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  shift_mode_e      mode,
  output logic [WIDTH-1:0] next,
  output logic             bit_out
);

  always_comb begin
    next    = data;
    bit_out = 1'b0;
    case (mode)
      ModeLsl: begin
        next    = {data[WIDTH-2:0], 1'b0};
        bit_out = data[WIDTH-1];
      end
      ModeLsr: begin
        next    = {1'b0, data[WIDTH-1:1]};
        bit_out = data[0];
      end
      ModeAsr: begin
        next    = {data[WIDTH-1], data[WIDTH-1:1]};
        bit_out = data[0];
      end
`ifdef SHIFT_ROTATE_EN
      ModeRor: begin
        next    = {data[0], data[WIDTH-1:1]};
        bit_out = data[0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: one bit per clock under a start/busy/done handshake.
// Define SHIFT_ROTATE_EN to enable rotate-right on mode 11; otherwise mode 11 flags err.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ip,
  input  logic [AW-1:0]    amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             err
);

`ifdef SHIFT_ROTATE_EN
  localparam bit RotateEn = 1'b1;
`else
  localparam bit RotateEn = 1'b0;
`endif

  shift_state_e     state_q;
  shift_mode_e      mode_q;
  logic [WIDTH-1:0] data_q;
  logic [AW-1:0]    cnt_q;
  logic             carry_w;

  logic [WIDTH-1:0] step_data;
  logic             step_bit;
  logic             skip_shift;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data   (data_q),
    .mode   (mode_q),
    .next   (step_data),
    .bit_out(step_bit)
  );

  // Zero-amount requests and unsupported rotate bypass the shift phase entirely.
  assign skip_shift = (amt == '0) || (!RotateEn && (shift_mode_e'(mode) == ModeRor));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mode_q  <= ModeLsl;
      data_q  <= '0;
      cnt_q   <= '0;
      carry_w <= 1'b0;
      out     <= '0;
      carry   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            data_q  <= ip;
            cnt_q   <= amt;
            mode_q  <= shift_mode_e'(mode);
            carry_w <= 1'b0;
            busy    <= 1'b1;
            state_q <= skip_shift ? StDone : StShift;
          end
        end
        StShift: begin
          data_q  <= step_data;
          carry_w <= step_bit;
          cnt_q   <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_q <= StDone;
        end
        StDone: begin
          out     <= data_q;
          carry   <= carry_w;
          err     <= !RotateEn && (mode_q == ModeRor);
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
